// File: rtl/cond_pkg.sv
// Shared encodings for the ARM condition field and the NZCV status flag positions.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/condition_check_if.sv
// Condition/status inputs and pass/fail outputs of the ID-stage condition checker.
interface condition_check_if;

    logic [3:0] condition;
    logic [3:0] status;
    logic       result;
    logic       result_q;

    modport master (
        output condition,
        output status,
        input  result,
        input  result_q
    );

    modport slave (
        input  condition,
        input  status,
        output result,
        output result_q
    );

endinterface

// File: rtl/condition_check.sv
// ARM condition-code evaluation against NZCV, combinational plus one registered copy.
// Build option COND_NV_UNCOND_EN: code 1111 passes (ARMv5+ unconditional space) instead of never.
module condition_check
    import cond_pkg::*;
(
    input  logic                 clock,
    input  logic                 rst,
    condition_check_if.slave     bus
);

    logic result_p0;
    logic result_p1;

    function automatic logic cond_eval(input cond_e c, input logic [3:0] s);
        logic n, z, cf, v;
        logic r;
        n  = s[FLAG_N];
        z  = s[FLAG_Z];
        cf = s[FLAG_C];
        v  = s[FLAG_V];
        r  = 1'b0;
        case (c)
            EQ: r = z;
            NE: r = ~z;
            CS: r = cf;
            CC: r = ~cf;
            MI: r = n;
            PL: r = ~n;
            VS: r = v;
            VC: r = ~v;
            HI: r = cf & ~z;
            LS: r = ~cf | z;
            GE: r = (n == v);
            LT: r = (n != v);
            GT: r = ~z & (n == v);
            LE: r = z | (n != v);
            AL: r = 1'b1;
`ifdef COND_NV_UNCOND_EN
            NV: r = 1'b1;
`else
            NV: r = 1'b0;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Stage p0: same-cycle evaluation
    assign result_p0  = cond_eval(cond_e'(bus.condition), bus.status);
    assign bus.result = result_p0;

    // Stage p1: registered copy for downstream stages
    always_ff @(posedge clock) begin
        if (rst) begin
            result_p1 <= 1'b0;
        end else begin
            result_p1 <= result_p0;
        end
    end

    assign bus.result_q = result_p1;

endmodule

// File: tb/tb_condition_check.sv
// Directed and exhaustive checks of condition_check, both combinational and registered outputs.
module tb_condition_check;

    logic clock;
    logic rst;
    int   n_checks;
    int   n_fails;

    condition_check_if bus ();

    condition_check dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic got, input logic want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got %b, expected %b", tag, got, want);
        end
    endtask

    // Independent reference: pairs of codes share a base test, odd code inverts it.
    function automatic logic ref_eval(input logic [3:0] c, input logic [3:0] s);
        logic n, z, cf, v, base;
        n  = s[3];
        z  = s[2];
        cf = s[1];
        v  = s[0];
        base = 1'b0;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n ~^ v);
            3'd6: base = !z && (n ~^ v);
            default: base = 1'b1;
        endcase
`ifdef COND_NV_UNCOND_EN
        if (c == 4'hF) return 1'b1;
`endif
        return c[0] ? !base : base;
    endfunction

    task automatic sweep(input logic [3:0] st, input logic [0:15] exp_v, input string nm);
        for (int i = 0; i < 16; i++) begin
            bus.condition = 4'(i);
            bus.status    = st;
            #1;
            check($sformatf("%s_c%0d", nm, i), bus.result, exp_v[i]);
            @(posedge clock);
            #1;
            check($sformatf("%s_q_c%0d", nm, i), bus.result_q, exp_v[i]);
        end
    endtask

    logic [0:15] exp_a;
    logic [0:15] exp_b;

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        bus.condition = 4'b1110;
        bus.status    = 4'b0000;

        // Reset held for two edges; combinational path ignores reset
        @(posedge clock);
        @(posedge clock);
        #1;
        check("reset_q", bus.result_q, 1'b0);
        check("reset_comb_al", bus.result, 1'b1);

        rst = 1'b0;
        @(posedge clock);
        #1;
        check("release_al_q", bus.result_q, 1'b1);

        exp_a = 16'b0110100110010110;
        exp_b = 16'b1001011001010110;
`ifdef COND_NV_UNCOND_EN
        exp_a[15] = 1'b1;
        exp_b[15] = 1'b1;
`endif
        sweep(4'b1010, exp_a, "st1010");
        sweep(4'b0101, exp_b, "st0101");

        // N == V with Z clear, C clear
        bus.status = 4'b1001;
        bus.condition = 4'b1010; #1; check("ge_nv", bus.result, 1'b1);
        bus.condition = 4'b1011; #1; check("lt_nv", bus.result, 1'b0);
        bus.condition = 4'b1100; #1; check("gt_nv", bus.result, 1'b1);
        bus.condition = 4'b1101; #1; check("le_nv", bus.result, 1'b0);
        bus.condition = 4'b1000; #1; check("hi_nv", bus.result, 1'b0);
        bus.condition = 4'b1001; #1; check("ls_nv", bus.result, 1'b1);

        // NV code against any status
        bus.condition = 4'b1111;
        bus.status    = 4'b0110;
        #1;
`ifdef COND_NV_UNCOND_EN
        check("nv_build", bus.result, 1'b1);
`else
        check("nv_build", bus.result, 1'b0);
`endif

        // Reset asserted mid-stream
        bus.condition = 4'b1110;
        @(posedge clock);
        #1;
        check("pre_rst_q", bus.result_q, 1'b1);
        rst = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_q", bus.result_q, 1'b0);
        check("mid_rst_comb", bus.result, 1'b1);
        bus.condition = 4'b0000;
        bus.status    = 4'b0100;
        #1;
        check("mid_rst_track", bus.result, 1'b1);
        rst = 1'b0;
        @(posedge clock);
        #1;
        check("post_rst_q", bus.result_q, 1'b1);

        // Exhaustive against the reference model
        for (int k = 0; k < 256; k++) begin
            bus.condition = 4'(k >> 4);
            bus.status    = 4'(k);
            #1;
            check($sformatf("exh_c%0d_s%0d", k >> 4, k & 15), bus.result,
                  ref_eval(4'(k >> 4), 4'(k)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/condition_check.md
Name: condition_check

Overview:
- Evaluates the 4-bit ARM condition field of an instruction against the NZCV status flags in the ID stage.
- Produces a pass/fail bit that gates execution of the instruction.
- The combinational result is available in the same cycle.
- A registered copy is provided for downstream pipeline use.

Parameters:
- None. All widths are fixed: 4-bit condition, 4-bit status.

Ports:
- clock  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- condition  input  4  ARM condition field (instr[31:28])
- status  input  4  flags; bit3=N, bit2=Z, bit1=C, bit0=V
- result  output  1  combinational: 1 = condition passes
- result_q  output  1  result registered on the rising edge of clock

Behaviour:
- Reset: clock and rst follow the fixed decision (one clock; synchronous, active-high reset).
  - While rst=1 at a rising edge, result_q <= 0.
  - result is purely combinational and is unaffected by reset.
- Condition table for result (zero-latency, recomputed on any input change):
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS/HS: C
  - 0011 CC/LO: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: !Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 AL: 1
  - 1111 NV: 0 (default build; see Optional Feature)
- result_q:
  - At each rising edge with rst=0, result_q <= result.
  - Latency is exactly 1 cycle.
  - There is no enable; the register updates every cycle.
- Purity:
  - No X propagation beyond inputs; result depends only on condition and status.
  - No internal state other than result_q.
- Reset mid-operation: on the next edge with rst=1, result_q goes to 0; result continues to track inputs.

Optional Feature:
- Macro: COND_NV_UNCOND_EN.
- Defined: condition 1111 evaluates to 1, matching the ARMv5+ unconditional space.
- Undefined: condition 1111 evaluates to 0 (NV, never).
- All other codes are identical in both builds.

Decomposition:
- Shared package cond_pkg containing:
  - enum cond_e with the 16 mnemonics EQ..NV and their encodings above.
  - Flag index constants: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- No sub-module. Evaluation is a single case statement or function inside condition_check, plus one flop for result_q.

Test Plan:
- status=1010 (N1 Z0 C1 V0), sweep condition 0..15:
  - result = 0,1,1,0,1,0,0,1,1,0,0,1,0,1,1,0 (NV=0 in default build).
- status=0101 (N0 Z1 C0 V1), sweep condition 0..15:
  - result = 1,0,0,1,0,1,1,0,0,1,0,1,0,1,1,0.
- GE/GT with N=V, status=1001 (N1 Z0 C0 V1):
  - GE=1, LT=0, GT=1, LE=0, HI=0, LS=1.
- Registered path:
  - Hold rst=1 for 2 edges -> result_q=0.
  - Release; condition=1110 -> result_q=1 one edge later.
  - Assert rst mid-stream -> result_q=0 at that edge.
- Build with COND_NV_UNCOND_EN, condition=1111, any status -> result=1; without the macro -> result=0.
- Exhaustive: all 256 {condition, status} combinations compared against a reference model of the table, for both builds.
